// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer, instruction memory and ALU:
// opcode encodings, ALU operation codes and the sequencer state enum.
package control_sequencer_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_PC_STEP  = 32'd4;

    localparam logic [2:0] OP_LW      = 3'b000;
    localparam logic [2:0] OP_SW      = 3'b001;
    localparam logic [2:0] OP_ADD     = 3'b010;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_AND     = 3'b100;
    localparam logic [2:0] OP_OR      = 3'b101;
    localparam logic [2:0] OP_BEQ     = 3'b110;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAddr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExec,
        StAluWb,
        StBranch,
        StHalt
    } state_t;

endpackage

// File: rtl/control_pc_reg.sv
// Program counter register: steps sequentially or adds a branch offset.
module control_pc_reg
    import control_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load_step,
    input  logic        i_load_branch,
    input  logic [31:0] i_imm,
    output logic [31:0] o_pc
);

    logic [31:0] r_pc;

    // Branch load takes priority; both paths wrap modulo 2^32.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_load_branch) begin
            r_pc <= r_pc + i_imm;
        end else if (i_load_step) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control FSM: steps each instruction through fetch/decode/execute/
// memory/write-back, drives datapath strobes, counts retired instructions.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [2:0]  i_opcode,
    input  logic [31:0] i_imm,
    input  logic        i_alu_zero,
    input  logic        i_mem_ready,
    output logic [31:0] o_pc,
    output logic        o_reg_write,
    output logic        o_mem_to_reg,
    output logic        o_alu_src_imm,
    output logic [2:0]  o_alu_op,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_retired,
    output logic        o_halted
);

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_opcode;
    logic [31:0] r_retired;
    logic        w_retire;
    logic        w_load_branch;
    logic        w_load_step;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StFetch;
            r_opcode  <= OP_LW;
            r_retired <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StDecode) begin
                r_opcode <= i_opcode;
            end
            if (w_retire) begin
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StFetch:    w_state_next = StDecode;
            StDecode: begin
                unique case (i_opcode)
                    OP_LW, OP_SW:                  w_state_next = StMemAddr;
                    OP_ADD, OP_SUB, OP_AND, OP_OR: w_state_next = StExec;
                    OP_BEQ:                        w_state_next = StBranch;
                    default:                       w_state_next = StHalt;
                endcase
            end
            StMemAddr:  w_state_next = (r_opcode == OP_LW) ? StMemRead : StMemWrite;
            StMemRead:  w_state_next = i_mem_ready ? StMemWb : StMemRead;
            StMemWb:    w_state_next = StFetch;
            StMemWrite: w_state_next = i_mem_ready ? StFetch : StMemWrite;
            StExec:     w_state_next = StAluWb;
            StAluWb:    w_state_next = StFetch;
            StBranch:   w_state_next = StFetch;
            StHalt:     w_state_next = StHalt;
            default:    w_state_next = StFetch;
        endcase
    end

    // Retire handling only; the datapath strobes below never see mem_ready.
    always_comb begin
        w_retire = 1'b0;
        unique case (r_state)
            StMemWb, StAluWb, StBranch: w_retire = 1'b1;
            StMemWrite:                 w_retire = i_mem_ready;
            default:                    w_retire = 1'b0;
        endcase
        w_load_branch = (r_state == StBranch) && i_alu_zero;
        w_load_step   = w_retire && !w_load_branch;
    end

    always_comb begin
        o_reg_write   = 1'b0;
        o_mem_to_reg  = 1'b0;
        o_alu_src_imm = 1'b0;
        o_alu_op      = ALU_ADD;
        o_mem_req     = 1'b0;
        o_mem_we      = 1'b0;
        o_halted      = 1'b0;
        unique case (r_state)
            StMemAddr: begin
                o_alu_src_imm = 1'b1;
                o_alu_op      = ALU_ADD;
            end
            StMemRead: o_mem_req = 1'b1;
            StMemWb: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
            end
            StMemWrite: begin
                o_mem_req = 1'b1;
                o_mem_we  = 1'b1;
            end
            StExec: o_alu_op = r_opcode;
            StAluWb: begin
                o_reg_write = 1'b1;
                o_alu_op    = r_opcode;
            end
            StBranch: o_alu_op = ALU_SUB;
            StHalt:   o_halted = 1'b1;
            default: ;
        endcase
    end

    control_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_load_step   (w_load_step),
        .i_load_branch (w_load_branch),
        .i_imm         (i_imm),
        .o_pc          (o_pc)
    );

    assign o_retired = r_retired;

endmodule
